// File: rtl/cpu_fetch_queue_if.sv
// Fetch -> decode queue bus: producer push side, consumer pop side and occupancy status.
// master = fetch/decode environment, slave = the queue itself.
interface cpu_fetch_queue_if #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a word moves on a side exactly in a cycle where that side's valid and ready
  // are both high at the rising edge; valid never waits on ready, and o_ready depends only on
  // registered state (no i_ready -> o_ready path).
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_almost_full;
  logic          o_empty;

  modport master (
    output i_flush, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count, o_almost_full, o_empty
  );

  modport slave (
    input  i_flush, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count, o_almost_full, o_empty
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// Fetch-to-decode FIFO with first-word fall-through, flush and occupancy status.
// Optional zero-latency pass-through when empty: define CPU_FETCH_QUEUE_BYPASS_EN.
module cpu_fetch_queue #(
  parameter int DW          = 64,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  cpu_fetch_queue_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] ZERO_C  = '0;
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic stored_valid;
  logic push;
  logic pop;
  logic pass_through;

  assign stored_valid = (count_q != ZERO_C);

  always_comb begin
    pass_through = 1'b0;
`ifdef CPU_FETCH_QUEUE_BYPASS_EN
    // An empty queue hands the offered word straight to a ready consumer without storing it.
    pass_through = !stored_valid && bus.i_valid && !bus.i_flush && bus.i_ready;
`endif
    push = bus.i_valid && (count_q != DEPTH_C) && !pass_through;
    pop  = stored_valid && bus.i_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge i_clock) begin
    if (push && !bus.i_flush) mem_q[wr_ptr_q] <= bus.i_data;
  end

  always_comb begin
    bus.o_valid = stored_valid;
    bus.o_data  = mem_q[rd_ptr_q];
`ifdef CPU_FETCH_QUEUE_BYPASS_EN
    if (!stored_valid && bus.i_valid && !bus.i_flush) begin
      bus.o_valid = 1'b1;
      bus.o_data  = bus.i_data;
    end
`endif
  end

  assign bus.o_ready       = (count_q != DEPTH_C);
  assign bus.o_count       = count_q;
  assign bus.o_almost_full = (count_q >= AF_C);
  assign bus.o_empty       = (count_q == ZERO_C);

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench for cpu_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_cpu_fetch_queue;
  localparam int DW          = 64;
  localparam int DEPTH       = 4;
  localparam int ALMOST_FULL = 3;
`ifdef CPU_FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic i_clock;
  logic i_reset;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] model_q[$];

  cpu_fetch_queue_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  cpu_fetch_queue #(.DW(DW), .DEPTH(DEPTH), .ALMOST_FULL(ALMOST_FULL)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the model says the queue should show right now.
  task automatic check_outputs(input string tag);
    int sz;
    logic exp_valid;
    logic [DW-1:0] exp_data;
    sz = model_q.size();
    exp_valid = (sz != 0);
    exp_data  = (sz != 0) ? model_q[0] : '0;
    if (BYPASS && sz == 0 && bus.i_valid && !bus.i_flush) begin
      exp_valid = 1'b1;
      exp_data  = bus.i_data;
    end
    check_eq({tag, ".o_valid"}, DW'(bus.o_valid), DW'(exp_valid));
    if (exp_valid) check_eq({tag, ".o_data"}, bus.o_data, exp_data);
    check_eq({tag, ".o_count"}, DW'(bus.o_count), DW'(sz));
    check_eq({tag, ".o_ready"}, DW'(bus.o_ready), DW'(sz != DEPTH));
    check_eq({tag, ".o_almost_full"}, DW'(bus.o_almost_full), DW'(sz >= ALMOST_FULL));
    check_eq({tag, ".o_empty"}, DW'(bus.o_empty), DW'(sz == 0));
  endtask

  // Driver: one clock cycle with the given inputs; outputs checked mid-cycle, model updated at the edge.
  task automatic cycle(input string tag, input logic flush, input logic valid,
                       input logic [DW-1:0] data, input logic rdy);
    int sz;
    bit take;
    bit accept;
    @(negedge i_clock);
    bus.i_flush = flush;
    bus.i_valid = valid;
    bus.i_data  = data;
    bus.i_ready = rdy;
    #1;
    check_outputs(tag);
    @(posedge i_clock);
    sz = model_q.size();
    if (flush) begin
      model_q.delete();
    end else if (BYPASS && sz == 0 && valid && rdy) begin
      // word passes straight through, nothing stored
    end else begin
      take   = (sz > 0) && rdy;
      accept = valid && (sz < DEPTH);
      if (take) void'(model_q.pop_front());
      if (accept) model_q.push_back(data);
    end
  endtask

  task automatic idle_cycle(input string tag);
    cycle(tag, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    i_reset = 1'b0;
    #1;
    check_eq("reset.o_valid", DW'(bus.o_valid), 0);
    check_eq("reset.o_count", DW'(bus.o_count), 0);
    check_eq("reset.o_ready", DW'(bus.o_ready), 1);
    check_eq("reset.o_empty", DW'(bus.o_empty), 1);
    check_eq("reset.o_almost_full", DW'(bus.o_almost_full), 0);
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;

    // Fill: 1..4 with consumer stalled, 5th refused, then drain in order
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b0, 1'b1, DW'(i), 1'b0);
    cycle("fill_refuse", 1'b0, 1'b1, DW'(5), 1'b0);
    check_eq("fill.count_after_refuse", DW'(bus.o_count), DW'(DEPTH));
    // Full + pop: one pop, push refused, then accepted next cycle
    cycle("full_pop", 1'b0, 1'b1, DW'(6), 1'b1);
    cycle("full_pop_next", 1'b0, 1'b1, DW'(6), 1'b0);
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 1'b0, '0, 1'b1);
    idle_cycle("drained");

    // Wrap: count held at 1 while 10 words stream through
    cycle("wrap_prime", 1'b0, 1'b1, DW'(0), 1'b0);
    for (int i = 1; i <= 10; i++) cycle("wrap", 1'b0, 1'b1, DW'(i), 1'b1);
    cycle("wrap_drain", 1'b0, 1'b0, '0, 1'b1);
    idle_cycle("wrap_done");

    // Flush with a push in the same cycle: 0x77 must be dropped
    cycle("flush_fill", 1'b0, 1'b1, DW'('h11), 1'b0);
    cycle("flush_fill", 1'b0, 1'b1, DW'('h22), 1'b0);
    cycle("flush", 1'b1, 1'b1, DW'('h77), 1'b0);
    for (int i = 0; i < 3; i++) cycle("post_flush", 1'b0, 1'b0, '0, 1'b1);

    // Bypass / latency: empty queue, push 0x55 with consumer ready
    cycle("bypass", 1'b0, 1'b1, DW'('h55), 1'b1);
    cycle("bypass_after", 1'b0, 1'b0, '0, 1'b1);
    idle_cycle("bypass_idle");

    // Asynchronous reset mid-traffic with count = 3
    for (int i = 0; i < 3; i++) cycle("pre_reset", 1'b0, 1'b1, DW'('hB0 + i), 1'b0);
    @(negedge i_clock);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b0;
    #2;
    i_reset = 1'b0;
    #1;
    model_q.delete();
    check_eq("async_reset.o_valid", DW'(bus.o_valid), 0);
    check_eq("async_reset.o_count", DW'(bus.o_count), 0);
    check_eq("async_reset.o_ready", DW'(bus.o_ready), 1);
    check_eq("async_reset.o_empty", DW'(bus.o_empty), 1);
    @(negedge i_clock);
    i_reset = 1'b1;
    cycle("post_reset_push", 1'b0, 1'b1, DW'('hA5), 1'b0);
    cycle("post_reset_pop", 1'b0, 1'b0, '0, 1'b1);
    idle_cycle("post_reset_idle");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) != 0),
            {$urandom, $urandom},
            ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
